bus_uart_responder: RTL and testbench
=====================================

Name: bus_uart_responder

Overview:
- Memory-mapped UART peripheral on the CPU's 8-bit address / 8-bit data bus. The CPU is the bus initiator; this block is a responder at a fixed base address.
- Converts register writes into 8N1 serial transmission and received serial frames into readable registers.
- Intended as the serial path around the limited TinyTapeout pin count. The top level muxes its read_data onto the CPU read path when selected is high.

Parameters:
- BUS_ADDRESS_WIDTH, 8, width of address bus.
- BASE_ADDRESS, 8'hF0, address of register offset 0. Must be 4-aligned.
- DEFAULT_DIVISOR, 8'd7, reset value of DIVISOR. Clocks per bit = DIVISOR+1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous reset, active low.
- address  input  BUS_ADDRESS_WIDTH  bus address from CPU.
- write_enable  input  1  bus write strobe, sampled at rising clk.
- write_data  input  8  bus write data.
- read_data  output  8  combinational read of addressed register; 0 when not selected.
- selected  output  1  combinational; high when address is in BASE_ADDRESS..BASE_ADDRESS+3.
- uart_rx  input  1  asynchronous serial input, idle high.
- uart_tx  output  1  registered serial output, idle high.
- irq  output  1  registered; equals rx_valid | rx_overrun | rx_frame_error.

Behaviour:
- Reset is synchronous, active low (rst_n=0 at rising clk).
  - Reset values: uart_tx=1, irq=0, TXDATA=0, RXDATA=0, DIVISOR=DEFAULT_DIVISOR, all status bits 0.
  - Both FSMs return to IDLE.
  - Reset mid-frame aborts the frame; uart_tx is high the cycle after reset.
- Register map, by offset from BASE_ADDRESS:
  - +0 TXDATA. Write: accepted only if tx_busy=0, which loads the shifter and starts a frame. Write while busy is ignored, and TXDATA and tx_busy are unchanged. Read: last accepted byte.
  - +1 RXDATA. Read only; writes ignored. Reads have no side effects.
  - +2 STATUS. bit0 tx_busy (RO), bit1 rx_valid, bit2 rx_overrun, bit3 rx_frame_error, bits7:4 read 0. Writing 1 to bits1..3 clears them (W1C); writing 0 has no effect.
  - +3 DIVISOR. Read/write. Written values below 3 are stored as 3.
- Bus timing:
  - Zero-wait-state bus.
  - Writes take effect at the rising clk where write_enable=1 and selected=1.
  - Reads are combinational from current register state.
  - Writes to unselected addresses are ignored.
- Frame format: 8N1, LSB first. Bit period P = DIVISOR+1 clocks.
  - DIVISOR is latched into the TX counter at frame start and into the RX counter at start-bit detect.
  - A DIVISOR change mid-frame affects only the next frame.
- TX FSM (IDLE, START, DATA, STOP):
  - Accepted write at edge N: tx_busy=1 and uart_tx=0 after edge N.
  - START lasts P cycles, then DATA lasts 8 bits of P cycles each, then STOP (uart_tx=1) lasts P cycles.
  - tx_busy falls 10*P cycles after edge N, and the FSM returns to IDLE.
  - A write in the final STOP cycle is ignored because busy is still 1. A write in the first IDLE cycle is accepted, giving back-to-back frames with no idle gap.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE: a synchronized falling edge enters START.
  - START: wait floor(P/2) cycles, then sample. If the sample is high it is a glitch: return to IDLE with no status change. If low, enter DATA.
  - DATA: sample 8 bits, each P cycles apart, LSB first.
  - STOP: sample P cycles later.
  - Stop sampled 1 and rx_valid=0: RXDATA is updated and rx_valid is set.
  - Stop sampled 1 and rx_valid=1: the new byte is dropped and rx_overrun is set.
  - Stop sampled 0: the byte is dropped and rx_frame_error is set.
  - After the stop sample the FSM returns to IDLE immediately.
- Simultaneous events: a hardware set and a W1C clear of the same bit in the same cycle resolve to set=1.
  - Example: rx_valid clear coincides with a completed frame. The result is RXDATA updated, rx_valid=1, and no overrun.
- irq is updated one cycle after the status bits change.

Test Plan:
- Reset, then bus reads at F0..F3 -> 00, 00, 00, 07. Read of EF -> 00 with selected=0. uart_tx=1.
- Write 8'hA5 to F0 at edge N, DIVISOR=7 -> uart_tx, one level per 8 cycles: 0,1,0,1,0,0,1,0,1,1. STATUS bit0 set from N through N+79, clear at N+80. A second write of 8'h3C at N+40 is ignored: TXDATA reads A5.
- Drive 8'h5A frame on uart_rx at P=8 -> STATUS=8'h02, RXDATA=5A, irq=1 one cycle after rx_valid. Write 8'h02 to F2 -> STATUS=00, irq=0.
- Two frames 8'h11 then 8'h22 with no clear between -> RXDATA=11, STATUS=8'h06. Write 8'h06 -> STATUS=00.
- Frame with stop bit 0 -> STATUS=8'h08, RXDATA unchanged. A 2-cycle low glitch on uart_rx -> no status change.
- Write 8'h01 to F3 -> DIVISOR reads 03, frames at P=4. Assert rst_n=0 mid-TX frame -> uart_tx=1 and STATUS=00 the next cycle, DIVISOR=07.

Source files
------------

// File: rtl/bus_uart_responder_if.sv
// CPU-side bus of the UART responder: 8-bit data, parameterised address, combinational reads.
interface bus_uart_responder_if #(
  parameter int unsigned BUS_ADDRESS_WIDTH = 8
) ();
  logic [BUS_ADDRESS_WIDTH-1:0] address;
  logic                         write_enable;
  logic [7:0]                   write_data;
  logic [7:0]                   read_data;
  logic                         selected;

  modport master (
    output address,
    output write_enable,
    output write_data,
    input  read_data,
    input  selected
  );

  modport slave (
    input  address,
    input  write_enable,
    input  write_data,
    output read_data,
    output selected
  );
endinterface

// File: rtl/bus_uart_responder.sv
// Memory-mapped 8N1 UART responder: TXDATA, RXDATA, STATUS, DIVISOR at BASE_ADDRESS+0..3.
// Bus reads are combinational; register writes, the serial line and irq are registered.
module bus_uart_responder #(
  parameter int unsigned                  BUS_ADDRESS_WIDTH = 8,
  parameter logic [BUS_ADDRESS_WIDTH-1:0] BASE_ADDRESS      = 8'hF0,
  parameter logic [7:0]                   DEFAULT_DIVISOR   = 8'd7
) (
  input  logic                clk,
  input  logic                rst_n,
  bus_uart_responder_if.slave bus,
  input  logic                uart_rx,
  output logic                uart_tx,
  output logic                irq
);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  localparam logic [7:0] MinDivisor = 8'd3;

  logic [1:0] offset;
  logic       wr_en, wr_div, tx_busy, tx_start;
  logic       clr_valid, clr_overrun, clr_frame_error;

  logic [7:0] txdata_q, rxdata_q, divisor_q;
  logic       rx_valid_q, rx_overrun_q, rx_frame_error_q, irq_q;
  logic       rx_valid_d, rx_overrun_d, rx_frame_error_d;

  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_cnt_q, tx_cnt_d, tx_shift_q, tx_shift_d, tx_period_q, tx_period_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       tx_line_q, tx_line_d;

  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] rx_cnt_q, rx_cnt_d, rx_shift_q, rx_shift_d, rx_period_q, rx_period_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [8:0] rx_half;
  logic       rx_meta_q, rx_sync_q, rx_prev_q, rx_fall, rx_done, rx_accept;

  // Bus decode and register read mux
  assign bus.selected = (bus.address[BUS_ADDRESS_WIDTH-1:2]
                         == BASE_ADDRESS[BUS_ADDRESS_WIDTH-1:2]);
  assign offset          = bus.address[1:0];
  assign wr_en           = bus.write_enable & bus.selected;
  assign wr_div          = wr_en && (offset == 2'd3);
  assign tx_start        = wr_en && (offset == 2'd0) && (tx_state_q == TxIdle);
  assign clr_valid       = wr_en && (offset == 2'd2) && bus.write_data[1];
  assign clr_overrun     = wr_en && (offset == 2'd2) && bus.write_data[2];
  assign clr_frame_error = wr_en && (offset == 2'd2) && bus.write_data[3];

  always_comb begin
    bus.read_data = '0;
    if (bus.selected) begin
      case (offset)
        2'd0:    bus.read_data = txdata_q;
        2'd1:    bus.read_data = rxdata_q;
        2'd2:    bus.read_data = {4'b0, rx_frame_error_q, rx_overrun_q, rx_valid_q, tx_busy};
        default: bus.read_data = divisor_q;
      endcase
    end
  end

  // A completed frame wins over a same-cycle W1C clear.
  assign rx_accept        = rx_done & rx_sync_q & ~(rx_valid_q & ~clr_valid);
  assign rx_valid_d       = (rx_valid_q & ~clr_valid) | rx_accept;
  assign rx_overrun_d     = (rx_overrun_q & ~clr_overrun) | (rx_done & rx_sync_q & ~rx_accept);
  assign rx_frame_error_d = (rx_frame_error_q & ~clr_frame_error) | (rx_done & ~rx_sync_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txdata_q         <= '0;
      rxdata_q         <= '0;
      divisor_q        <= DEFAULT_DIVISOR;
      rx_valid_q       <= 1'b0;
      rx_overrun_q     <= 1'b0;
      rx_frame_error_q <= 1'b0;
      irq_q            <= 1'b0;
      rx_meta_q        <= 1'b1;
      rx_sync_q        <= 1'b1;
      rx_prev_q        <= 1'b1;
    end else begin
      if (tx_start) txdata_q <= bus.write_data;
      if (rx_accept) rxdata_q <= rx_shift_q;
      if (wr_div) divisor_q <= (bus.write_data < MinDivisor) ? MinDivisor : bus.write_data;
      rx_valid_q       <= rx_valid_d;
      rx_overrun_q     <= rx_overrun_d;
      rx_frame_error_q <= rx_frame_error_d;
      irq_q            <= rx_valid_q | rx_overrun_q | rx_frame_error_q;
      rx_meta_q        <= uart_rx;
      rx_sync_q        <= rx_meta_q;
      rx_prev_q        <= rx_sync_q;
    end
  end

  // TX FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_period_q <= '0;
      tx_line_q   <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_period_q <= tx_period_d;
      tx_line_q   <= tx_line_d;
    end
  end

  // TX FSM: next state; each level is held for tx_period_q+1 clocks
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_period_d = tx_period_q;
    tx_line_d   = tx_line_q;
    case (tx_state_q)
      TxIdle: begin
        tx_line_d = 1'b1;
        if (tx_start) begin
          tx_state_d  = TxStart;
          tx_cnt_d    = '0;
          tx_period_d = divisor_q;
          tx_shift_d  = bus.write_data;
          tx_line_d   = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == tx_period_q) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 8'd1;
        end
      end
      TxData: begin
        if (tx_cnt_q == tx_period_q) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 8'd1;
        end
      end
      default: begin
        if (tx_cnt_q == tx_period_q) begin
          tx_state_d = TxIdle;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 8'd1;
        end
      end
    endcase
  end

  // TX/RX FSM outputs
  always_comb begin
    tx_busy = (tx_state_q != TxIdle);
    uart_tx = tx_line_q;
    irq     = irq_q;
  end

  // RX FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_period_q <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_period_q <= rx_period_d;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign rx_half = ({1'b0, rx_period_q} + 9'd1) >> 1;

  // RX FSM: next state; first sample lands mid start bit, then one sample per bit period
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_period_d = rx_period_q;
    rx_done     = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d  = RxStart;
          rx_cnt_d    = '0;
          rx_period_d = divisor_q;
        end
      end
      RxStart: begin
        if ({1'b0, rx_cnt_q} == rx_half - 9'd1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 8'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == rx_period_q) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 8'd1;
        end
      end
      default: begin
        if (rx_cnt_q == rx_period_q) begin
          rx_state_d = RxIdle;
          rx_cnt_d   = '0;
          rx_done    = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 8'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bus_uart_responder.sv
// Self-checking bench for bus_uart_responder: register vectors, TX frame timing and RX status
// handling against a frame-level model, plus randomized TX/RX traffic.
module tb_bus_uart_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic uart_rx;
  logic uart_tx;
  logic irq;

  bus_uart_responder_if #(.BUS_ADDRESS_WIDTH(8)) bus ();

  bus_uart_responder #(
    .BUS_ADDRESS_WIDTH(8),
    .BASE_ADDRESS     (8'hF0),
    .DEFAULT_DIVISOR  (8'd7)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model of the receive-side registers
  logic [7:0] m_rxdata;
  logic       m_valid, m_ovr, m_ferr;

  typedef struct {
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] raddr;
    logic [7:0] rdata;
    logic       rsel;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.address = a;
    #1;
    d = bus.read_data;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address      = a;
    bus.write_data   = d;
    bus.write_enable = 1'b1;
    @(negedge clk);
    bus.write_enable = 1'b0;
  endtask

  task automatic model_reset();
    m_rxdata = 8'h00;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_ferr   = 1'b0;
  endtask

  task automatic model_clear(input logic [7:0] mask);
    if (mask[1]) m_valid = 1'b0;
    if (mask[2]) m_ovr = 1'b0;
    if (mask[3]) m_ferr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_rxdata = d;
      m_valid  = 1'b1;
    end
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] v;
    rd(8'hF2, v);
    check({tag, " status"}, v, {4'b0, m_ferr, m_ovr, m_valid, 1'b0});
    rd(8'hF1, v);
    check({tag, " rxdata"}, v, m_rxdata);
    check({tag, " irq"}, irq, m_valid | m_ovr | m_ferr);
  endtask

  // Entered at the negedge right after the accepting edge N; checks every cycle to N+10P.
  task automatic tx_frame_check(input logic [7:0] d, input int p, input int inject_k,
                                input logic [7:0] inject_a, input logic [7:0] inject_d);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int k = 0; k < 10 * p; k++) begin
      if (k > 0) @(negedge clk);
      bus.write_enable = 1'b0;
      bus.address      = 8'hF2;
      #1;
      check($sformatf("tx line k=%0d", k), uart_tx, bits[k/p]);
      check($sformatf("tx busy k=%0d", k), bus.read_data[0], 1'b1);
      if (k == inject_k) begin
        bus.address      = inject_a;
        bus.write_data   = inject_d;
        bus.write_enable = 1'b1;
      end
    end
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.address      = 8'hF2;
    #1;
    check("tx busy after frame", bus.read_data[0], 1'b0);
    check("tx line after frame", uart_tx, 1'b1);
  endtask

  // Drives one frame on uart_rx and records when rx_valid and irq first read high.
  task automatic send_frame(input logic [7:0] d, input int p, input logic stop, input int clr_at,
                            output int v_at, output int i_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    v_at = -1;
    i_at = -1;
    bus.address = 8'hF2;
    for (int c = 0; c < 12 * p; c++) begin
      @(negedge clk);
      bus.write_enable = 1'b0;
      if (v_at < 0 && bus.read_data[1]) v_at = c;
      if (i_at < 0 && irq) i_at = c;
      uart_rx = (c < 10 * p) ? bits[c/p] : 1'b1;
      if (c == clr_at) begin
        bus.write_data   = 8'h02;
        bus.write_enable = 1'b1;
      end
    end
    @(negedge clk);
    bus.write_enable = 1'b0;
  endtask

  task automatic glitch();
    @(negedge clk);
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[14];
    logic [7:0] got, d, mask;
    int         va, ia, cur_p, new_p, p;
    logic       stop;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'hF1, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'hF2, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'hF3, 8'h07, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'hEF, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'hF4, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 8'hF3, 8'h01, 8'hF3, 8'h03, 1'b1};
    vecs[7]  = '{1'b1, 8'hF3, 8'h00, 8'hF3, 8'h03, 1'b1};
    vecs[8]  = '{1'b1, 8'hF3, 8'h02, 8'hF3, 8'h03, 1'b1};
    vecs[9]  = '{1'b1, 8'hF3, 8'hC8, 8'hF3, 8'hC8, 1'b1};
    vecs[10] = '{1'b1, 8'hF1, 8'h55, 8'hF1, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 8'hF2, 8'hFF, 8'hF2, 8'h00, 1'b1};
    vecs[12] = '{1'b1, 8'hE3, 8'h09, 8'hF3, 8'hC8, 1'b1};
    vecs[13] = '{1'b1, 8'hF3, 8'h07, 8'hF3, 8'h07, 1'b1};

    rst_n            = 1'b0;
    uart_rx          = 1'b1;
    bus.address      = 8'h00;
    bus.write_data   = 8'h00;
    bus.write_enable = 1'b0;
    model_reset();
    tick(3);
    rst_n = 1'b1;
    #1;
    check("reset uart_tx", uart_tx, 1'b1);
    check("reset irq", irq, 1'b0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, got);
      check($sformatf("vec %0d read", i), got, vecs[i].rdata);
      check($sformatf("vec %0d selected", i), bus.selected, vecs[i].rsel);
    end

    // A5 at P=8, with a 3C write at N+40 that must be ignored
    wr(8'hF0, 8'hA5);
    tx_frame_check(8'hA5, 8, 39, 8'hF0, 8'h3C);
    rd(8'hF0, got);
    check("txdata after busy write", got, 8'hA5);

    // Write in the last STOP cycle is dropped; write in the first idle cycle starts a frame
    wr(8'hF0, 8'h0F);
    tx_frame_check(8'h0F, 8, 79, 8'hF0, 8'h77);
    bus.address      = 8'hF0;
    bus.write_data   = 8'hE1;
    bus.write_enable = 1'b1;
    @(negedge clk);
    tx_frame_check(8'hE1, 8, -1, 8'h00, 8'h00);
    rd(8'hF0, got);
    check("txdata back-to-back", got, 8'hE1);

    // Randomized TX with occasional DIVISOR change mid-frame
    cur_p = $urandom_range(4, 10);
    wr(8'hF3, 8'(cur_p - 1));
    for (int it = 0; it < 4; it++) begin
      d     = 8'($urandom);
      new_p = $urandom_range(4, 10);
      wr(8'hF0, d);
      tx_frame_check(d, cur_p, $urandom_range(1, 30), 8'hF3, 8'(new_p - 1));
      cur_p = new_p;
    end
    wr(8'hF3, 8'h07);

    // RX 5A: rx_valid, then irq one cycle later; W1C clears both
    send_frame(8'h5A, 8, 1'b1, -1, va, ia);
    model_frame(8'h5A, 1'b1);
    check_rx("rx 5A");
    check("irq one cycle after rx_valid", ia - va, 1);
    wr(8'hF2, 8'h02);
    model_clear(8'h02);
    tick(2);
    check_rx("rx 5A cleared");

    // Overrun: second byte dropped
    send_frame(8'h11, 8, 1'b1, -1, va, ia);
    model_frame(8'h11, 1'b1);
    send_frame(8'h22, 8, 1'b1, -1, va, ia);
    model_frame(8'h22, 1'b1);
    check_rx("rx overrun");
    wr(8'hF2, 8'h06);
    model_clear(8'h06);
    tick(2);
    check_rx("rx overrun cleared");

    // Framing error, then a short glitch that must not disturb anything
    send_frame(8'h96, 8, 1'b0, -1, va, ia);
    model_frame(8'h96, 1'b0);
    check_rx("rx frame error");
    glitch();
    check_rx("rx glitch");
    wr(8'hF2, 8'h08);
    model_clear(8'h08);
    tick(2);
    check_rx("rx ferr cleared");

    // rx_valid clear landing on the stop-sample edge: the new byte wins, no overrun
    send_frame(8'h33, 8, 1'b1, -1, va, ia);
    model_frame(8'h33, 1'b1);
    send_frame(8'h44, 8, 1'b1, 78, va, ia);
    model_clear(8'h02);
    model_frame(8'h44, 1'b1);
    check_rx("rx set beats clear");

    // Randomized RX traffic
    for (int it = 0; it < 12; it++) begin
      p = $urandom_range(4, 10);
      wr(8'hF3, 8'(p - 1));
      if ($urandom_range(0, 1) == 1) begin
        mask = 8'($urandom);
        wr(8'hF2, mask);
        model_clear(mask);
      end
      if ($urandom_range(0, 7) == 0) begin
        glitch();
      end else begin
        d    = 8'($urandom);
        stop = ($urandom_range(0, 4) != 0);
        send_frame(d, p, stop, -1, va, ia);
        model_frame(d, stop);
      end
      check_rx($sformatf("rx random %0d", it));
    end

    // DIVISOR floor of 3 gives P=4 frames in both directions
    wr(8'hF3, 8'h01);
    rd(8'hF3, got);
    check("divisor floor", got, 8'h03);
    wr(8'hF0, 8'hC3);
    tx_frame_check(8'hC3, 4, -1, 8'h00, 8'h00);
    wr(8'hF2, 8'h0E);
    model_clear(8'h0E);
    send_frame(8'h6D, 4, 1'b1, -1, va, ia);
    model_frame(8'h6D, 1'b1);
    check_rx("rx P=4");

    // Reset in the middle of a data bit that drives the line low
    wr(8'hF0, 8'h80);
    tick(15);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("mid-frame reset uart_tx", uart_tx, 1'b1);
    rd(8'hF3, got);
    check("reset divisor", got, 8'h07);
    rd(8'hF0, got);
    check("reset txdata", got, 8'h00);
    check_rx("after reset");
    tick(3);
    check("uart_tx idle after reset", uart_tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
